// File: rtl/fetch_ctrl_pkg.sv
// Shared configuration for the fetch sequencer: widths, opcodes
// and the FSM state encoding.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BREACH = 7'b1100011;

    localparam logic TRUE = 1'b1;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_ctrl_bpu.sv
// Static branch predictor: redirect wins, then JAL, then
// backward branches taken, everything else falls through.
module fetch_ctrl_bpu
    import fetch_ctrl_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] imm_i,
    input  logic [6:0]   opcode_i,
    input  logic         flush_flag_i,
    input  logic [W-1:0] flush_addr_i,
    output logic [W-1:0] pc_pred_o
);

    always_comb begin
        pc_pred_o = pc_i + W'(4);
        priority case (TRUE)
            flush_flag_i:
                pc_pred_o = flush_addr_i;
            (opcode_i == OPCODE_JAL):
                pc_pred_o = pc_i + imm_i;
            (opcode_i == OPCODE_BREACH) && imm_i[W-1]:
                pc_pred_o = pc_i + imm_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, one outstanding imem request,
// one-entry decode buffer, flush redirect with stale-response drop.
module fetch_ctrl #(
    parameter int                          XLEN     = fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0]             RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_flag,
    input  logic [XLEN-1:0] flush_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pred_pc
);

    import fetch_ctrl_pkg::*;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pred_q, id_pred_d;

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_pred;
    logic            req_hs;
    logic            load;

    assign opcode = imem_rsp_data[6:0];

    always_comb begin
        imm = '0;
        priority case (TRUE)
            (opcode == OPCODE_JAL):
                imm = {{(XLEN-20){imem_rsp_data[31]}},
                       imem_rsp_data[19:12],
                       imem_rsp_data[20],
                       imem_rsp_data[30:21], 1'b0};
            (opcode == OPCODE_BREACH):
                imm = {{(XLEN-12){imem_rsp_data[31]}},
                       imem_rsp_data[7],
                       imem_rsp_data[30:25],
                       imem_rsp_data[11:8], 1'b0};
            default: ;
        endcase
    end

    fetch_ctrl_bpu #(
        .W(XLEN)
    ) u_bpu (
        .pc_i        (pc_q),
        .imm_i       (imm),
        .opcode_i    (opcode),
        .flush_flag_i(flush_flag),
        .flush_addr_i(flush_addr),
        .pc_pred_o   (pc_pred)
    );

    // Held low while reset is asserted so no request leaks out of reset.
    assign imem_req_valid = rst_n && (state_q == REQ) &&
                            (!id_valid_q || id_ready);
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign load           = (state_q == WAIT) && imem_rsp_valid &&
                            !flush_flag;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q && !id_ready;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_pred_d  = id_pred_q;

        unique case (state_q)
            REQ: begin
                if (req_hs)
                    state_d = flush_flag ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid)
                    state_d = REQ;
                else if (flush_flag)
                    state_d = DROP;
            end
            DROP: begin
                if (imem_rsp_valid)
                    state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (load) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rsp_data;
            id_pc_d    = pc_q;
            id_pred_d  = pc_pred;
            pc_d       = pc_pred;
        end

        if (flush_flag) begin
            id_valid_d = 1'b0;
            pc_d       = flush_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            id_pred_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_pred_q  <= id_pred_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_inst    = id_inst_q;
    assign id_pc      = id_pc_q;
    assign id_pred_pc = id_pred_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the IFU.
- Owns the architectural fetch PC and issues one instruction-memory request at a time.
- Extracts opcode and immediate from each returned instruction and drives the static branch predictor (bpu) to choose the next PC.
- Presents fetched instructions to decode through a one-entry valid/ready buffer. Pipeline flush redirects are handled here, including discarding stale in-flight responses.

Parameters:
- XLEN, 32, datapath/PC width (from the shared config).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; one clock domain.
- flush_flag  in  1  redirect request from the execute stage.
- flush_addr  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  instruction return valid. Always accepted; at most one outstanding.
- imem_rsp_data  in  32  returned instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes.
- id_inst  out  32  instruction.
- id_pc  out  XLEN  PC of id_inst.
- id_pred_pc  out  XLEN  predicted next PC, used by execute to detect mispredicts.

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything. It sets:
  - state=REQ, pc=RESET_PC
  - imem_req_valid=0, id_valid=0
  - id_inst=0, id_pc=0, id_pred_pc=0
  - A response arriving during or just after reset is ignored: state REQ does not sample rsp.
- States: REQ, WAIT, DROP.
- REQ:
  - imem_req_valid = (!id_valid || id_ready); imem_req_addr = pc.
  - Leaves REQ only on the handshake (valid && ready), going to WAIT.
- WAIT, on imem_rsp_valid (no flush):
  - Load id_inst=rsp_data, id_pc=pc, id_pred_pc=pc_pred; id_valid=1.
  - pc <= pc_pred; go to REQ.
  - Response-to-id_valid latency is one cycle. Minimum request-to-request spacing is 2 cycles (REQ→WAIT→REQ with a zero-wait memory).
- Immediate extraction (combinational, from rsp_data):
  - JAL (opcode 7'b1101111): imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - BRANCH (opcode 7'b1100011): imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - Any other opcode: imm = 0.
- bpu, instantiated with:
  - pc = current pc, imm and opcode as above, flush_flag/flush_addr from the ports.
  - Resulting pc_pred:
    - flush: flush_addr
    - JAL: pc+imm
    - backward branch (imm[31]=1): pc+imm
    - otherwise: pc+4
  - All additions are modulo 2^XLEN (wrap, no overflow flag).
- Output buffer:
  - id_valid clears on id_ready when no new response is loaded that cycle.
  - Load and consume in the same cycle: the new instruction replaces the old one and id_valid stays 1.
  - Buffer contents are stable while id_valid && !id_ready.
- Flush (flush_flag=1) overrides normal transitions in every state:
  - id_valid <= 0 and pc <= flush_addr.
  - REQ without handshake: stay in REQ; the address changes to flush_addr from the next cycle.
  - REQ with handshake that same cycle: the old-address request is in flight; go to DROP.
  - WAIT without rsp: go to DROP.
  - WAIT with rsp the same cycle: the response is discarded and not loaded into the buffer; go to REQ.
  - DROP: stay in DROP, or go to REQ if rsp arrives the same cycle.
- DROP:
  - imem_req_valid=0; the next imem_rsp_valid is discarded.
  - Then go to REQ with pc unchanged, i.e. the redirect target.
- Back-to-back flushes: the latest flush_addr wins; at most one response is ever pending a drop.
- Flush asserted together with id_ready: id_valid becomes 0, and the consumed instruction still counts as delivered.

Decomposition:
- Shared config package holds:
  - XLEN
  - OPCODE_JAL, OPCODE_BREACH (branch opcode)
  - the true constant
  - state encodings: REQ=2'd0, WAIT=2'd1, DROP=2'd2
- Sub-module: the existing bpu, instantiated once.
- Immediate extraction stays inline as combinational logic.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory returning ADDI (0x00000013), id_ready=1 → requests at 0x100, 0x104, 0x108 every 2 cycles; id_pc follows the same sequence; id_pred_pc=id_pc+4.
- Fetch at 0x200 returns JAL imm=-16 (0xFF1FF06F) → id_pred_pc=0x1F0; next imem_req_addr=0x1F0.
- Branch at 0x300: BEQ offset -8 (0xFE000CE3) → next fetch 0x2F8. Branch offset +8 (0x00000463) → next fetch 0x304.
- Flush in WAIT with flush_addr=0x400; rsp (stale) arrives 3 cycles later → stale rsp never reaches id_valid; next request addr=0x400, issued the cycle after the stale rsp.
- id_ready=0 for 5 cycles after the first instruction → id_valid/id_inst stable; imem_req_valid=0 until id_ready rises; no instruction lost or duplicated.
- Flush and rsp in the same WAIT cycle, and rst_n=0 mid-WAIT → the first case goes to REQ with flush_addr and does not load the response. For reset: all outputs return to reset values the next cycle; a following rsp_valid is ignored; fetch restarts at RESET_PC.
